// File: rtl/div_seq_ctrl.sv
// Sequential signed restoring divider for the ALU multi-cycle path.
// Start/done handshake, registered quotient, remainder and status flags.
module div_seq_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] qmag;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;
  logic             zero_b;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             ovf;
  logic             last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; a zero divisor skips the iterations
  // and still finishes through FIX
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = PREP;
      PREP: state_nx = zero_in() ? FIX : ITER;
      ITER: if (last) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  function automatic logic zero_in();
    return (b_r == '0);
  endfunction

  // Operand magnitudes, trial subtraction and sign fix-up
  always_comb begin
    a_abs   = a_r[WIDTH-1] ? (~a_r + 1'b1) : a_r;
    b_abs   = b_r[WIDTH-1] ? (~b_r + 1'b1) : b_r;
    shifted = {prem, dvd[WIDTH-1]};
    trial   = shifted - {1'b0, dsr};
    q_fix   = sign_q ? (~qmag + 1'b1) : qmag;
    r_fix   = sign_r ? (~prem + 1'b1) : prem;
    ovf     = (a_r == MINV) && (b_r == '1);
    last    = (cnt == LAST);
  end

  // Datapath registers and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      prem        <= '0;
      qmag        <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_b      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r         <= a;
            b_r         <= b;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        PREP: begin
          dvd    <= a_abs;
          dsr    <= b_abs;
          sign_q <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
          sign_r <= a_r[WIDTH-1];
          zero_b <= zero_in();
          prem   <= '0;
          cnt    <= '0;
        end
        ITER: begin
          dvd  <= {dvd[WIDTH-2:0], 1'b0};
          prem <= trial[WIDTH] ? shifted[WIDTH-1:0]
                               : trial[WIDTH-1:0];
          qmag <= {qmag[WIDTH-2:0], ~trial[WIDTH]};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          if (zero_b) begin
            quotient    <= '0;
            remainder   <= a_r;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
            overflow    <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered handshake outputs derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx == PREP) || (state_nx == ITER) ||
              (state_nx == FIX);
      done <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed and sweep bench for div_seq_ctrl.
// Hand-computed vectors plus a full operand sweep.
module tb_div_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] a;
  logic [5:0] b;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [5:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  div_seq_ctrl #(.WIDTH(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs,
                      input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation; lat = edges from acceptance to the done cycle
  task automatic do_op(input logic [5:0] ta, input logic [5:0] tb_v,
                       input int glitch, output int lat,
                       output logic bz, output logic [5:0] q_acc,
                       output logic [1:0] f_acc);
    bz = 1'b1;
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (lat == 0) begin
        q_acc = quotient;
        f_acc = {div_by_zero, overflow};
        a = ~ta;
        b = ~tb_v;
      end
      start = (lat == glitch);
      if (lat == glitch) begin
        a = 6'd1;
        b = 6'd1;
      end
      if (done) break;
      if (!busy) bz = 1'b0;
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  int         lat;
  logic       bz;
  logic [5:0] q_acc;
  logic [1:0] f_acc;
  logic [5:0] eq;
  logic [5:0] er;
  logic       edz;
  logic       eov;
  int         elat;
  logic       seen_done;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk6("rst_q", quotient, 6'd0);
    chk6("rst_r", remainder, 6'd0);
    chk("rst_flags", int'({div_by_zero, overflow}), 0);
    rst_n = 1'b1;

    do_op(6'd20, 6'd3, -1, lat, bz, q_acc, f_acc);
    chk("lat_20_3", lat, 8);
    chk("busy_20_3", int'(bz), 1);
    chk("busy_at_done", int'(busy), 0);
    chk6("q_20_3", quotient, 6'd6);
    chk6("r_20_3", remainder, 6'd2);
    chk("f_20_3", int'({div_by_zero, overflow}), 0);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);

    do_op(6'(-20), 6'd3, -1, lat, bz, q_acc, f_acc);
    chk6("q_m20_3", quotient, 6'(-6));
    chk6("r_m20_3", remainder, 6'(-2));
    do_op(6'd7, 6'(-2), -1, lat, bz, q_acc, f_acc);
    chk6("q_7_m2", quotient, 6'(-3));
    chk6("r_7_m2", remainder, 6'd1);
    do_op(6'(-7), 6'(-2), -1, lat, bz, q_acc, f_acc);
    chk6("q_m7_m2", quotient, 6'd3);
    chk6("r_m7_m2", remainder, 6'(-1));
    do_op(6'(-32), 6'd31, -1, lat, bz, q_acc, f_acc);
    chk6("q_m32_31", quotient, 6'(-1));
    chk6("r_m32_31", remainder, 6'(-1));
    chk("f_m32_31", int'({div_by_zero, overflow}), 0);

    do_op(6'(-32), 6'(-1), -1, lat, bz, q_acc, f_acc);
    chk("lat_ovf", lat, 8);
    chk6("q_ovf", quotient, 6'(-32));
    chk6("r_ovf", remainder, 6'd0);
    chk("f_ovf", int'({div_by_zero, overflow}), 1);
    repeat (3) @(negedge clk);
    chk6("hold_q", quotient, 6'(-32));
    chk("hold_ovf", int'(overflow), 1);

    do_op(6'(-32), 6'd1, -1, lat, bz, q_acc, f_acc);
    chk6("acc_q_held", q_acc, 6'(-32));
    chk("acc_flags_clr", int'(f_acc), 0);
    chk6("q_m32_1", quotient, 6'(-32));
    chk6("r_m32_1", remainder, 6'd0);
    chk("f_m32_1", int'({div_by_zero, overflow}), 0);

    do_op(6'd5, 6'd0, -1, lat, bz, q_acc, f_acc);
    chk("lat_dz", lat, 2);
    chk6("q_dz", quotient, 6'd0);
    chk6("r_dz", remainder, 6'd5);
    chk("f_dz", int'({div_by_zero, overflow}), 2);

    do_op(6'd9, 6'd4, -1, lat, bz, q_acc, f_acc);
    chk("acc_dz_clr", int'(f_acc), 0);

    @(negedge clk);
    a = 6'd20;
    b = 6'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", int'(busy), 0);
    chk("mr_done", int'(done), 0);
    chk6("mr_q", quotient, 6'd0);
    chk6("mr_r", remainder, 6'd0);
    chk("mr_flags", int'({div_by_zero, overflow}), 0);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) seen_done = 1'b1;
    end
    chk("mr_no_done", int'(seen_done), 0);
    do_op(6'd9, 6'd4, -1, lat, bz, q_acc, f_acc);
    chk6("q_9_4", quotient, 6'd2);
    chk6("r_9_4", remainder, 6'd1);

    do_op(6'd20, 6'd3, 3, lat, bz, q_acc, f_acc);
    chk("lat_glitch", lat, 8);
    chk6("q_glitch", quotient, 6'd6);
    chk6("r_glitch", remainder, 6'd2);
    @(negedge clk);
    chk("glitch_idle", int'(busy), 0);

    for (int i = -32; i < 32; i++) begin
      for (int j = -32; j < 32; j++) begin
        if (j == 0) begin
          eq = 6'd0;
          er = 6'(i);
          edz = 1'b1;
          eov = 1'b0;
          elat = 2;
        end else begin
          eq = 6'(i / j);
          er = 6'(i % j);
          edz = 1'b0;
          eov = (i == -32) && (j == -1);
          elat = 8;
        end
        do_op(6'(i), 6'(j), -1, lat, bz, q_acc, f_acc);
        checks++;
        assert ({quotient, remainder, div_by_zero, overflow} ===
                {eq, er, edz, eov} && lat == elat && bz) else begin
          errors++;
          $error("FAIL sweep a=%0d b=%0d: got q=%0h r=%0h dz=%0b ov=%0b lat=%0d expected q=%0h r=%0h dz=%0b ov=%0b lat=%0d",
                 i, j, quotient, remainder, div_by_zero, overflow,
                 lat, eq, er, edz, eov, elat);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
